// File: rtl/minv_pkg.sv
// Shared FSM state definitions for the iterative modular inverse core.
package minv_pkg;

    localparam logic [1:0] ENC_IDLE  = 2'b00;
    localparam logic [1:0] ENC_CHECK = 2'b01;
    localparam logic [1:0] ENC_ITER  = 2'b10;
    localparam logic [1:0] ENC_FIN   = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = ENC_IDLE,
        CHECK = ENC_CHECK,
        ITER  = ENC_ITER,
        FIN   = ENC_FIN
    } state_t;

endpackage

// File: rtl/minv_modsub.sv
// Combinational (x - y) mod p for x, y already reduced into [0, p).
module minv_modsub
    import minv_pkg::*;
#(
    parameter int N = 256
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic [N-1:0] p,
    output logic [N-1:0] r
);

    logic [N:0] diff;

    // The extra top bit of the difference acts as the borrow/sign flag.
    assign diff = {1'b0, x} - {1'b0, y};
    assign r    = diff[N] ? (diff[N-1:0] + p) : diff[N-1:0];

endmodule

// File: rtl/minv_iter_core.sv
// Binary extended-GCD modular inverse, one reduction step per ITER cycle.
// Define MINV_MOD_CHECK_EN to reject even moduli and moduli below 3 in CHECK.
module minv_iter_core
    import minv_pkg::*;
#(
    parameter int N     = 256,
    parameter int CNT_W = $clog2(2*N+2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N-1:0]     a_in,
    input  logic [N-1:0]     p_in,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [N-1:0]     inv_out,
    output logic [CNT_W-1:0] iter_cnt
);

    localparam logic [CNT_W-1:0] ITER_CAP = CNT_W'(2*N);
    localparam logic [N-1:0]     ONE      = N'(1);

    state_t           state_reg, state_next;
    logic [N-1:0]     u_reg, u_next;
    logic [N-1:0]     v_reg, v_next;
    logic [N-1:0]     x1_reg, x1_next;
    logic [N-1:0]     x2_reg, x2_next;
    logic [N-1:0]     p_reg, p_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             fail_reg, fail_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             err_reg, err_next;
    logic [N-1:0]     inv_reg, inv_next;
    logic             mod_bad;

    // Index 0 is the x1 path, index 1 the x2 path.
    logic [N-1:0] x_cur  [2];
    logic [N-1:0] x_half [2];
    logic [N-1:0] x_sub  [2];

    assign x_cur[0] = x1_reg;
    assign x_cur[1] = x2_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_xpath
            // Odd values are made even by adding p; the N+1-bit sum keeps the carry.
            assign x_half[gi] = x_cur[gi][0]
                              ? N'(({1'b0, x_cur[gi]} + {1'b0, p_reg}) >> 1)
                              : (x_cur[gi] >> 1);

            minv_modsub #(.N(N)) u_modsub (
                .x (x_cur[gi]),
                .y (x_cur[1-gi]),
                .p (p_reg),
                .r (x_sub[gi])
            );
        end
    endgenerate

`ifdef MINV_MOD_CHECK_EN
    assign mod_bad = ~p_reg[0] | (p_reg < N'(3));
`else
    assign mod_bad = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        u_next     = u_reg;
        v_next     = v_reg;
        x1_next    = x1_reg;
        x2_next    = x2_reg;
        p_next     = p_reg;
        cnt_next   = cnt_reg;
        fail_next  = fail_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        err_next   = err_reg;
        inv_next   = inv_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = CHECK;
                    u_next     = a_in;
                    v_next     = p_in;
                    p_next     = p_in;
                    x1_next    = ONE;
                    x2_next    = '0;
                    cnt_next   = '0;
                    fail_next  = 1'b0;
                    busy_next  = 1'b1;
                    err_next   = 1'b0;
                    inv_next   = '0;
                end
            end

            CHECK: begin
                if ((u_reg == '0) || mod_bad) begin
                    fail_next  = 1'b1;
                    state_next = FIN;
                end else begin
                    // One subtraction only; the iteration tolerates u >= p afterwards.
                    if (u_reg >= v_reg) begin
                        u_next = u_reg - v_reg;
                    end
                    state_next = ITER;
                end
            end

            ITER: begin
                cnt_next = cnt_reg + CNT_W'(1);
                if (!u_reg[0]) begin
                    u_next  = u_reg >> 1;
                    x1_next = x_half[0];
                end else if (!v_reg[0]) begin
                    v_next  = v_reg >> 1;
                    x2_next = x_half[1];
                end else if (u_reg >= v_reg) begin
                    u_next  = u_reg - v_reg;
                    x1_next = x_sub[0];
                end else begin
                    v_next  = v_reg - u_reg;
                    x2_next = x_sub[1];
                end

                // Termination is judged on the freshly stepped values.
                if ((u_next == ONE) || (v_next == ONE)) begin
                    state_next = FIN;
                end else if ((u_next == '0) || (v_next == '0) || (cnt_next == ITER_CAP)) begin
                    fail_next  = 1'b1;
                    state_next = FIN;
                end
            end

            FIN: begin
                state_next = IDLE;
                done_next  = 1'b1;
                busy_next  = 1'b0;
                err_next   = fail_reg;
                if (fail_reg) begin
                    inv_next = '0;
                end else if (u_reg == ONE) begin
                    inv_next = x1_reg;
                end else begin
                    inv_next = x2_reg;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            u_reg     <= '0;
            v_reg     <= '0;
            x1_reg    <= '0;
            x2_reg    <= '0;
            p_reg     <= '0;
            cnt_reg   <= '0;
            fail_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            inv_reg   <= '0;
        end else begin
            state_reg <= state_next;
            u_reg     <= u_next;
            v_reg     <= v_next;
            x1_reg    <= x1_next;
            x2_reg    <= x2_next;
            p_reg     <= p_next;
            cnt_reg   <= cnt_next;
            fail_reg  <= fail_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
            inv_reg   <= inv_next;
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign err      = err_reg;
    assign inv_out  = inv_reg;
    assign iter_cnt = cnt_reg;

endmodule

// File: tb/tb_minv_iter_core.sv
// Scoreboard bench for minv_iter_core at N=8, N=16 and a bank of N=256 instances.
`timescale 1ns/1ps
module tb_minv_iter_core;

    localparam int NB     = 256;
    localparam int K      = 20;
    localparam int ROUNDS = 50;

    typedef struct {
        logic [NB-1:0] inv;
        logic          err;
        int            iters;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   t0_8, t0_16;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        start8, busy8, done8, err8;
    logic [7:0]  a8, p8, inv8;
    logic [4:0]  iter8;
    logic        start16, busy16, done16, err16;
    logic [15:0] a16, p16, inv16;
    logic [5:0]  iter16;
    logic          start256 [K];
    logic [NB-1:0] a256     [K];
    logic [NB-1:0] p256     [K];
    logic          busy256  [K];
    logic          done256  [K];
    logic          err256   [K];
    logic [NB-1:0] inv256   [K];
    logic [9:0]    iter256  [K];

    minv_iter_core #(.N(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a_in(a8), .p_in(p8),
        .busy(busy8), .done(done8), .err(err8), .inv_out(inv8), .iter_cnt(iter8)
    );

    minv_iter_core #(.N(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a_in(a16), .p_in(p16),
        .busy(busy16), .done(done16), .err(err16), .inv_out(inv16), .iter_cnt(iter16)
    );

    generate
        for (genvar gi = 0; gi < K; gi++) begin : g_big
            minv_iter_core #(.N(NB)) u_dut256 (
                .clk(clk), .rst_n(rst_n), .start(start256[gi]), .a_in(a256[gi]), .p_in(p256[gi]),
                .busy(busy256[gi]), .done(done256[gi]), .err(err256[gi]),
                .inv_out(inv256[gi]), .iter_cnt(iter256[gi])
            );
        end
    endgenerate

    // Reference: the same step rules, written with plain comparisons on 257-bit values.
    function automatic void ref_minv(input logic [NB-1:0] a, input logic [NB-1:0] p,
                                     output logic [NB-1:0] inv, output logic err, output int iters);
        logic [NB:0] u, v, x1, x2, pp;
        bit fin;
        pp = {1'b0, p}; u = {1'b0, a}; v = pp; x1 = 1; x2 = 0;
        iters = 0; inv = '0; err = 1'b0; fin = 1'b0;
        if (a == '0) begin
            err = 1'b1;
            fin = 1'b1;
        end else if (u >= v) begin
            u = u - v;
        end
        while (!fin) begin
            if (u[0] == 1'b0) begin
                u = u >> 1;
                x1 = x1[0] ? (x1 + pp) >> 1 : x1 >> 1;
            end else if (v[0] == 1'b0) begin
                v = v >> 1;
                x2 = x2[0] ? (x2 + pp) >> 1 : x2 >> 1;
            end else if (u >= v) begin
                u = u - v;
                x1 = (x1 >= x2) ? x1 - x2 : x1 + pp - x2;
            end else begin
                v = v - u;
                x2 = (x2 >= x1) ? x2 - x1 : x2 + pp - x1;
            end
            iters++;
            if (u == 1) begin
                inv = x1[NB-1:0]; fin = 1'b1;
            end else if (v == 1) begin
                inv = x2[NB-1:0]; fin = 1'b1;
            end else if (u == 0 || v == 0 || iters == 2*NB) begin
                err = 1'b1; fin = 1'b1;
            end
        end
    endfunction

    task automatic pulse8(input logic [7:0] a, input logic [7:0] p);
        start8 = 1'b1; a8 = a; p8 = p; t0_8 = cyc;
        @(posedge clk); #1;
        start8 = 1'b0;
    endtask

    task automatic pulse16(input logic [15:0] a, input logic [15:0] p);
        start16 = 1'b1; a16 = a; p16 = p; t0_16 = cyc;
        @(posedge clk); #1;
        start16 = 1'b0;
    endtask

    task automatic wait8(input int limit, output int lat, output bit to);
        int n = 0;
        while (done8 !== 1'b1 && n < limit) begin
            @(posedge clk); #1; n++;
        end
        to  = (done8 !== 1'b1);
        lat = cyc - t0_8;
    endtask

    task automatic wait16(input int limit, output int lat, output bit to);
        int n = 0;
        while (done16 !== 1'b1 && n < limit) begin
            @(posedge clk); #1; n++;
        end
        to  = (done16 !== 1'b1);
        lat = cyc - t0_16;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; p8 = '0;
        start16 = 1'b0; a16 = '0; p16 = '0;
        for (int i = 0; i < K; i++) begin
            start256[i] = 1'b0; a256[i] = '0; p256[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL reset_busy8: got %b want 0", busy8); end
        n_checks++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL reset_done8: got %b want 0", done8); end
        n_checks++; if (err8 !== 1'b0) begin n_fail++; $display("FAIL reset_err8: got %b want 0", err8); end
        n_checks++; if (inv8 !== 8'd0) begin n_fail++; $display("FAIL reset_inv8: got %0d want 0", inv8); end
        n_checks++; if (iter8 !== 5'd0) begin n_fail++; $display("FAIL reset_iter8: got %0d want 0", iter8); end
        n_checks++; if (busy256[0] !== 1'b0 || done256[0] !== 1'b0) begin
            n_fail++; $display("FAIL reset_big: busy=%b done=%b want 0/0", busy256[0], done256[0]);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        $display("reset: busy8=%b done8=%b err8=%b inv8=%0d iter8=%0d", busy8, done8, err8, inv8, iter8);
    endtask

    task automatic test_vectors8;
        int ta[6] = '{3, 13, 1, 6, 7, 0};
        int tp[6] = '{7, 11, 7, 9, 7, 7};
        int ti[6] = '{5, 6, 1, 0, 0, 0};
        int te[6] = '{0, 0, 0, 1, 1, 1};
        int tn[6] = '{3, 1, 1, 4, 1, 0};
        exp_t e, g;
        int lat;
        bit to;
        for (int j = 0; j < 6; j++) begin
            e.inv = NB'(ti[j]); e.err = te[j][0]; e.iters = tn[j];
            sb_q.push_back(e);
            pulse8(8'(ta[j]), 8'(tp[j]));
            n_checks++; if (busy8 !== 1'b1) begin n_fail++; $display("FAIL vec8_busy[%0d]: got %b want 1", j, busy8); end
            wait8(2*8+10, lat, to);
            g = sb_q.pop_front();
            n_checks++; if (to) begin n_fail++; $display("FAIL vec8_timeout[%0d]: done=%b want 1", j, done8); end
            n_checks++; if (inv8 !== g.inv[7:0]) begin n_fail++; $display("FAIL vec8_inv[%0d]: got %0d want %0d", j, inv8, g.inv[7:0]); end
            n_checks++; if (err8 !== g.err) begin n_fail++; $display("FAIL vec8_err[%0d]: got %b want %b", j, err8, g.err); end
            n_checks++; if (int'(iter8) !== g.iters) begin n_fail++; $display("FAIL vec8_iter[%0d]: got %0d want %0d", j, iter8, g.iters); end
            n_checks++; if (lat !== g.iters + 3) begin n_fail++; $display("FAIL vec8_latency[%0d]: got %0d want %0d", j, lat, g.iters + 3); end
            n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL vec8_busy_at_done[%0d]: got %b want 0", j, busy8); end
            $display("vec8 a=%0d p=%0d inv=%0d err=%b iter=%0d lat=%0d", ta[j], tp[j], inv8, err8, iter8, lat);
            @(posedge clk); #1;
            n_checks++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL vec8_done_pulse[%0d]: got %b want 0", j, done8); end
            n_checks++; if (inv8 !== g.inv[7:0]) begin n_fail++; $display("FAIL vec8_inv_hold[%0d]: got %0d want %0d", j, inv8, g.inv[7:0]); end
        end
    endtask

    task automatic test_n16;
        int ta[2] = '{2, 0};
        int ti[2] = '{32761, 0};
        int te[2] = '{0, 1};
        int tn[2] = '{1, 0};
        exp_t e, g;
        int lat;
        bit to;
        for (int j = 0; j < 2; j++) begin
            e.inv = NB'(ti[j]); e.err = te[j][0]; e.iters = tn[j];
            sb_q.push_back(e);
            pulse16(16'(ta[j]), 16'd65521);
            wait16(2*16+10, lat, to);
            g = sb_q.pop_front();
            n_checks++; if (to) begin n_fail++; $display("FAIL n16_timeout[%0d]: done=%b want 1", j, done16); end
            n_checks++; if (inv16 !== g.inv[15:0]) begin n_fail++; $display("FAIL n16_inv[%0d]: got %0d want %0d", j, inv16, g.inv[15:0]); end
            n_checks++; if (err16 !== g.err) begin n_fail++; $display("FAIL n16_err[%0d]: got %b want %b", j, err16, g.err); end
            n_checks++; if (lat !== g.iters + 3) begin n_fail++; $display("FAIL n16_latency[%0d]: got %0d want %0d", j, lat, g.iters + 3); end
            $display("n16 a=%0d p=65521 inv=%0d err=%b iter=%0d lat=%0d", ta[j], inv16, err16, iter16, lat);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mod_check;
        exp_t g;
        int lat;
        bit to;
`ifdef MINV_MOD_CHECK_EN
        g.inv = '0; g.err = 1'b1; g.iters = 0;
        sb_q.push_back(g);
`endif
        pulse8(8'd3, 8'd8);
        wait8(2*8+10, lat, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL modchk_timeout: done=%b want 1", done8); end
        n_checks++; if (lat > 2*8+3) begin n_fail++; $display("FAIL modchk_latency_bound: got %0d want <= %0d", lat, 2*8+3); end
        n_checks++; if (int'(iter8) > 2*8) begin n_fail++; $display("FAIL modchk_iter_bound: got %0d want <= 16", iter8); end
`ifdef MINV_MOD_CHECK_EN
        g = sb_q.pop_front();
        n_checks++; if (err8 !== g.err) begin n_fail++; $display("FAIL modchk_err: got %b want %b", err8, g.err); end
        n_checks++; if (int'(iter8) !== g.iters) begin n_fail++; $display("FAIL modchk_iter: got %0d want %0d", iter8, g.iters); end
        n_checks++; if (inv8 !== g.inv[7:0]) begin n_fail++; $display("FAIL modchk_inv: got %0d want %0d", inv8, g.inv[7:0]); end
`endif
        $display("modchk a=3 p=8 err=%b iter=%0d lat=%0d", err8, iter8, lat);
        @(posedge clk); #1;
    endtask

    task automatic test_busy_ignore;
        exp_t e, g;
        int lat, extra;
        bit to;
        e.inv = NB'(5); e.err = 1'b0; e.iters = 3;
        sb_q.push_back(e);
        pulse8(8'd3, 8'd7);
        // Re-pulse during ITER and again in the FIN cycle, with different operands.
        @(posedge clk); #1; start8 = 1'b1; a8 = 8'd5; p8 = 8'd11;
        @(posedge clk); #1; start8 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; start8 = 1'b1; a8 = 8'd2; p8 = 8'd11;
        @(posedge clk); #1; start8 = 1'b0;
        wait8(2*8+10, lat, to);
        g = sb_q.pop_front();
        n_checks++; if (to) begin n_fail++; $display("FAIL busy_timeout: done=%b want 1", done8); end
        n_checks++; if (inv8 !== g.inv[7:0]) begin n_fail++; $display("FAIL busy_inv: got %0d want %0d", inv8, g.inv[7:0]); end
        n_checks++; if (int'(iter8) !== g.iters) begin n_fail++; $display("FAIL busy_iter: got %0d want %0d", iter8, g.iters); end
        n_checks++; if (lat !== g.iters + 3) begin n_fail++; $display("FAIL busy_latency: got %0d want %0d", lat, g.iters + 3); end
        extra = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (done8 === 1'b1 || busy8 === 1'b1) extra++;
        end
        n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL busy_ghost_op: got %0d active cycles want 0", extra); end
        $display("busy_ignore inv=%0d iter=%0d lat=%0d ghost=%0d", inv8, iter8, lat, extra);
    endtask

    task automatic test_back_to_back;
        exp_t e, g;
        int lat;
        bit to;
        e.inv = NB'(5); e.err = 1'b0; e.iters = 3;
        sb_q.push_back(e);
        e.inv = NB'(6); e.err = 1'b0; e.iters = 1;
        sb_q.push_back(e);
        pulse8(8'd3, 8'd7);
        for (int j = 0; j < 2; j++) begin
            wait8(2*8+10, lat, to);
            g = sb_q.pop_front();
            n_checks++; if (to) begin n_fail++; $display("FAIL b2b_timeout[%0d]: done=%b want 1", j, done8); end
            n_checks++; if (inv8 !== g.inv[7:0]) begin n_fail++; $display("FAIL b2b_inv[%0d]: got %0d want %0d", j, inv8, g.inv[7:0]); end
            n_checks++; if (lat !== g.iters + 3) begin n_fail++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", j, lat, g.iters + 3); end
            $display("b2b[%0d] inv=%0d err=%b iter=%0d lat=%0d", j, inv8, err8, iter8, lat);
            // Next start issued in the very cycle done is high.
            if (j == 0) pulse8(8'd2, 8'd11);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        exp_t e, g;
        int lat, seen;
        bit to;
        pulse16(16'd12345, 16'd65521);
        repeat (6) @(posedge clk);
        #1;
        n_checks++; if (busy16 !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before: got %b want 1", busy16); end
        rst_n = 1'b0;
        #1;
        n_checks++; if ({busy16, done16, err16} !== 3'b000) begin
            n_fail++; $display("FAIL rstmid_flags: got busy=%b done=%b err=%b want 0/0/0", busy16, done16, err16);
        end
        n_checks++; if (inv16 !== 16'd0 || iter16 !== 6'd0) begin
            n_fail++; $display("FAIL rstmid_data: got inv=%0d iter=%0d want 0/0", inv16, iter16);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done16 === 1'b1) seen++;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d done cycles want 0", seen); end
        e.inv = NB'(32761); e.err = 1'b0; e.iters = 1;
        sb_q.push_back(e);
        pulse16(16'd2, 16'd65521);
        wait16(2*16+10, lat, to);
        g = sb_q.pop_front();
        n_checks++; if (to) begin n_fail++; $display("FAIL rstmid_timeout: done=%b want 1", done16); end
        n_checks++; if (inv16 !== g.inv[15:0] || err16 !== g.err) begin
            n_fail++; $display("FAIL rstmid_after: got inv=%0d err=%b want %0d/%b", inv16, err16, g.inv[15:0], g.err);
        end
        $display("reset_mid ghost_done=%0d next inv=%0d lat=%0d", seen, inv16, lat);
        @(posedge clk); #1;
    endtask

    task automatic test_random256;
        logic [NB-1:0] ra [K];
        logic [NB-1:0] rp [K];
        int            lat [K];
        logic [2*NB-1:0] prod;
        exp_t e, g;
        int t0, n, pending;
        for (int r = 0; r < ROUNDS; r++) begin
            for (int i = 0; i < K; i++) begin
                for (int w = 0; w < NB/32; w++) begin
                    ra[i][w*32 +: 32] = $urandom;
                    rp[i][w*32 +: 32] = $urandom;
                end
                rp[i][0] = 1'b1;
                rp[i][NB-1] = 1'b1;
                ref_minv(ra[i], rp[i], e.inv, e.err, e.iters);
                sb_q.push_back(e);
                a256[i] = ra[i]; p256[i] = rp[i]; start256[i] = 1'b1; lat[i] = -1;
            end
            t0 = cyc;
            @(posedge clk); #1;
            for (int i = 0; i < K; i++) start256[i] = 1'b0;
            n = 0; pending = K;
            while (pending > 0 && n < 2*NB+10) begin
                @(posedge clk); #1; n++;
                pending = 0;
                for (int i = 0; i < K; i++) begin
                    if (lat[i] < 0 && done256[i] === 1'b1) lat[i] = cyc - t0;
                    if (lat[i] < 0) pending++;
                end
            end
            for (int i = 0; i < K; i++) begin
                g = sb_q.pop_front();
                n_checks++; if (lat[i] < 0) begin n_fail++; $display("FAIL rnd_timeout[%0d.%0d]: no done within %0d cycles", r, i, n); end
                n_checks++; if (err256[i] !== g.err) begin n_fail++; $display("FAIL rnd_err[%0d.%0d]: got %b want %b", r, i, err256[i], g.err); end
                n_checks++; if (int'(iter256[i]) !== g.iters) begin n_fail++; $display("FAIL rnd_iter[%0d.%0d]: got %0d want %0d", r, i, iter256[i], g.iters); end
                n_checks++; if (inv256[i] !== g.inv) begin n_fail++; $display("FAIL rnd_inv[%0d.%0d]: got %h want %h", r, i, inv256[i], g.inv); end
                n_checks++; if (int'(iter256[i]) > 2*NB) begin n_fail++; $display("FAIL rnd_iter_cap[%0d.%0d]: got %0d want <= %0d", r, i, iter256[i], 2*NB); end
                n_checks++; if (lat[i] !== int'(iter256[i]) + 3) begin n_fail++; $display("FAIL rnd_latency[%0d.%0d]: got %0d want %0d", r, i, lat[i], int'(iter256[i]) + 3); end
                if (!g.err) begin
                    prod = (2*NB)'(ra[i]) * (2*NB)'(inv256[i]);
                    prod = prod % (2*NB)'(rp[i]);
                    n_checks++; if (prod !== (2*NB)'(1)) begin n_fail++; $display("FAIL rnd_product[%0d.%0d]: a*inv mod p got %h want 1", r, i, prod); end
                end
                $display("rnd[%0d.%0d] err=%b iter=%0d lat=%0d", r, i, err256[i], iter256[i], lat[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

    initial begin
        test_reset();
        test_vectors8();
        test_n16();
        test_mod_check();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_random256();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
